in_unit: RTL

- Card-reader style input unit for the MIX CPU; the receive-side counterpart of the UART output unit.
- Takes ASCII bytes from a UART receiver, decodes each byte to a 6-bit MIX character code, and packs 5 codes per 30-bit word.
- Writes one block of BLOCK_WORDS words per input line into CPU memory, starting at the address given with `start`.
- Uses the same CPU handshake style as the output unit: `start`/`addressin`, then `stop` and `busy`.

---
 rtl/in_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/in_unit.sv
// MIX card-reader input unit: decodes UART bytes to MIX character codes and writes blocks of packed 30-bit words.
// Optional build macro LOWERCASE_FOLD_EN folds a-z onto A-Z; when it is undefined, a-z decode to 0.
module in_unit #(
    parameter int BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [11:0] addressin,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] addressout,
    output logic [29:0] dataout,
    output logic        write,
    input  logic        wack,
    output logic        stop,
    output logic        busy,
    output logic        overrun
);
    localparam int WCW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [WCW-1:0] WC_LAST = WCW'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        PAD   = 3'd2,
        SKIP  = 3'd3,
        FLUSH = 3'd4
    } state_t;

    state_t          r_state, w_state;
    logic [11:0]     r_addr, w_addr;
    logic [11:0]     r_addr_next, w_addr_next;
    logic [29:0]     r_data, w_data;
    logic [23:0]     r_shift, w_shift;
    logic [2:0]      r_cc, w_cc;
    logic [WCW-1:0]  r_wc, w_wc;
    logic            r_write, w_write;
    logic            r_stop, w_stop;
    logic            r_busy, w_busy;
    logic            r_overrun, w_overrun;
    logic            r_pending, w_pending;
    logic            w_push;
    logic [5:0]      w_code;
    logic            w_rx_cr, w_rx_lf;
    logic            w_unused;

    assign w_unused = rx_data[7];
    assign w_rx_cr  = rx_valid && (rx_data[6:0] == 7'd13);
    assign w_rx_lf  = rx_valid && (rx_data[6:0] == 7'd10);

    function automatic logic [5:0] f_decode(input logic [6:0] c);
        logic [6:0] u;
        logic [6:0] t;
        u = c;
`ifdef LOWERCASE_FOLD_EN
        if (c >= 7'd97 && c <= 7'd122) u = c - 7'd32;
`endif
        t = 7'd0;
        if (u >= 7'd65 && u <= 7'd73)      t = u - 7'd64;
        else if (u >= 7'd74 && u <= 7'd82) t = u - 7'd63;
        else if (u >= 7'd83 && u <= 7'd90) t = u - 7'd61;
        else if (u >= 7'd48 && u <= 7'd57) t = u - 7'd18;
        else begin
            case (u)
                7'd46:   t = 7'd40;
                7'd44:   t = 7'd41;
                7'd40:   t = 7'd42;
                7'd41:   t = 7'd43;
                7'd43:   t = 7'd44;
                7'd45:   t = 7'd45;
                7'd42:   t = 7'd46;
                7'd47:   t = 7'd47;
                7'd61:   t = 7'd48;
                default: t = 7'd0;
            endcase
        end
        return t[5:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state;
    end

    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_addr_next = r_addr_next;
        w_data      = r_data;
        w_shift     = r_shift;
        w_cc        = r_cc;
        w_wc        = r_wc;
        w_write     = r_write;
        w_stop      = 1'b0;
        w_busy      = r_busy;
        w_overrun   = r_overrun;
        w_pending   = r_pending;
        w_push      = 1'b0;
        w_code      = 6'd0;

        if (r_write && wack) begin
            w_write = 1'b0;
            w_addr  = r_addr + 12'd1;
        end
        if (start && r_busy) begin
            w_addr_next = addressin;
            w_pending   = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_busy  = 1'b1;
                    w_addr  = addressin;
                    w_stop  = 1'b1;
                    w_shift = 24'd0;
                    w_cc    = 3'd0;
                    w_wc    = '0;
                    w_state = RECV;
                end
            end
            RECV: begin
                if (w_rx_cr) begin
                    w_state = PAD;
                end else if (rx_valid && !w_rx_lf) begin
                    w_push = 1'b1;
                    w_code = f_decode(rx_data[6:0]);
                end
            end
            PAD: begin
                w_push = 1'b1;
            end
            SKIP: begin
                if (w_rx_cr) w_state = FLUSH;
            end
            FLUSH: begin
                // A start arriving in the completion cycle counts as a queued block.
                if (!r_write || wack) begin
                    w_pending = 1'b0;
                    if (r_pending || start) begin
                        w_stop  = 1'b1;
                        w_addr  = start ? addressin : r_addr_next;
                        w_state = RECV;
                    end else begin
                        w_busy  = 1'b0;
                        w_state = IDLE;
                    end
                end
            end
            default: w_state = IDLE;
        endcase

        if (w_push) begin
            if (r_cc == 3'd4) begin
                w_data  = {r_shift, w_code};
                w_write = 1'b1;
                if (r_write && !wack) w_overrun = 1'b1;
                w_shift = 24'd0;
                w_cc    = 3'd0;
                if (r_wc == WC_LAST) begin
                    w_wc    = '0;
                    w_state = (r_state == RECV) ? SKIP : FLUSH;
                end else begin
                    w_wc = r_wc + 1'b1;
                end
            end else begin
                w_shift = {r_shift[17:0], w_code};
                w_cc    = r_cc + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= 12'd0;
            r_addr_next <= 12'd0;
            r_data      <= 30'd0;
            r_shift     <= 24'd0;
            r_cc        <= 3'd0;
            r_wc        <= '0;
            r_write     <= 1'b0;
            r_stop      <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_addr      <= w_addr;
            r_addr_next <= w_addr_next;
            r_data      <= w_data;
            r_shift     <= w_shift;
            r_cc        <= w_cc;
            r_wc        <= w_wc;
            r_write     <= w_write;
            r_stop      <= w_stop;
            r_busy      <= w_busy;
            r_overrun   <= w_overrun;
            r_pending   <= w_pending;
        end
    end

    assign addressout = r_addr;
    assign dataout    = r_data;
    assign write      = r_write;
    assign stop       = r_stop;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule
